// File: rtl/e_mdu_ctrl.sv
// e_mdu_ctrl: multi-cycle mult/div controller with HI/LO registers and fixed-latency busy
module e_mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [3:0]  MDUop,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUout
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    op_q, op_d;
    logic [31:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic          busy_q, busy_d;
    logic          sgn, is_mul;
    logic [63:0]   prod;
    logic [31:0]   ua, ub, q, r, qs, rs;
    always_comb begin
        sgn    = (op_q == 4'd1) || (op_q == 4'd3);
        is_mul = (op_q == 4'd1) || (op_q == 4'd2);
        prod   = {{32{sgn & a_q[31]}}, a_q} * {{32{sgn & b_q[31]}}, b_q};
        // Divide on magnitudes so INT_MIN / -1 wraps cleanly to 0x80000000
        ua     = (sgn && a_q[31]) ? -a_q : a_q;
        ub     = (sgn && b_q[31]) ? -b_q : b_q;
        q      = ua / ub;
        r      = ua % ub;
        qs     = (sgn && (a_q[31] ^ b_q[31])) ? -q : q;
        rs     = (sgn && a_q[31]) ? -r : r;
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == IDLE) begin
            if (MDUop >= 4'd1 && MDUop <= 4'd4) begin
                state_d = RUN;
                op_d    = MDUop;
                a_d     = in1;
                b_d     = in2;
                cnt_d   = (MDUop <= 4'd2) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end else if (MDUop == 4'd7) begin
                hi_d = in1;
            end else if (MDUop == 4'd8) begin
                lo_d = in1;
            end
        end else begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = IDLE;
                if (is_mul) begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end else if (b_q != 32'd0) begin
                    hi_d = rs;
                    lo_d = qs;
                end
            end
        end
        busy_d = (state_d == RUN);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end
    assign busy   = busy_q;
    assign HI     = hi_q;
    assign LO     = lo_q;
    assign MDUout = (MDUop == 4'd5) ? hi_q : (MDUop == 4'd6) ? lo_q : 32'd0;
endmodule

// File: tb/tb_e_mdu_ctrl.sv
// tb_e_mdu_ctrl: directed checks of e_mdu_ctrl latency, results and reset
module tb_e_mdu_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in1 = '0, in2 = '0;
    logic [3:0]  MDUop = '0;
    logic        busy;
    logic [31:0] HI, LO, MDUout;
    int          total = 0, bad = 0, n;

    e_mdu_ctrl dut (
        .clk(clk), .reset(reset), .in1(in1), .in2(in2), .MDUop(MDUop),
        .busy(busy), .HI(HI), .LO(LO), .MDUout(MDUout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        MDUop = op;
        in1   = a;
        in2   = b;
        @(negedge clk);
        MDUop = 4'd0;
    endtask

    // Count busy cycles; optionally drive op/in1 for one edge during busy cycle 'at'
    task automatic wait_busy(input int at, input logic [3:0] op, input logic [31:0] a, output int cnt);
        cnt = 0;
        while (busy && cnt < 50) begin
            cnt++;
            MDUop = (cnt == at) ? op : 4'd0;
            in1   = a;
            in2   = 32'd3;
            @(negedge clk);
        end
        MDUop = 4'd0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        issue(4'd7, 32'hDEADBEEF, 32'd0);
        MDUop = 4'd5;
        #1;
        chk("mfhi", MDUout, 32'hDEADBEEF);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        MDUop = 4'd6;
        #1;
        chk("mflo", MDUout, 32'd0);
        MDUop = 4'd0;
        #1;
        chk("mdu_none", MDUout, 32'd0);
        @(negedge clk);

        issue(4'd1, 32'hFFFFFFFD, 32'd5);
        wait_busy(0, 4'd0, 32'd0, n);
        chk("mult_cyc", n, 32'd5);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFF1);

        issue(4'd2, 32'hFFFFFFFF, 32'd2);
        wait_busy(0, 4'd0, 32'd0, n);
        chk("multu_cyc", n, 32'd5);
        chk("multu_hi", HI, 32'h00000001);
        chk("multu_lo", LO, 32'hFFFFFFFE);

        issue(4'd3, 32'hFFFFFFF9, 32'd2);
        wait_busy(0, 4'd0, 32'd0, n);
        chk("div_cyc", n, 32'd10);
        chk("div_lo", LO, 32'hFFFFFFFD);
        chk("div_hi", HI, 32'hFFFFFFFF);

        issue(4'd4, 32'hFFFFFFF9, 32'd2);
        wait_busy(0, 4'd0, 32'd0, n);
        chk("divu_cyc", n, 32'd10);
        chk("divu_lo", LO, 32'h7FFFFFFC);
        chk("divu_hi", HI, 32'h00000001);

        issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_busy(0, 4'd0, 32'd0, n);
        chk("ovf_lo", LO, 32'h80000000);
        chk("ovf_hi", HI, 32'd0);

        issue(4'd7, 32'h1234, 32'd0);
        issue(4'd8, 32'h5678, 32'd0);
        issue(4'd3, 32'd99, 32'd0);
        // mthi on the completion edge must be ignored
        wait_busy(10, 4'd7, 32'h00000BAD, n);
        chk("dz_cyc", n, 32'd10);
        chk("dz_hi", HI, 32'h1234);
        chk("dz_lo", LO, 32'h5678);

        issue(4'd3, 32'd100, 32'd7);
        wait_busy(3, 4'd1, 32'd3, n);
        chk("ign_cyc", n, 32'd10);
        chk("ign_hi", HI, 32'd2);
        chk("ign_lo", LO, 32'd14);

        issue(4'd3, 32'd100, 32'd7);
        MDUop = 4'd5;
        #1;
        chk("mfhi_run", MDUout, 32'd2);
        MDUop = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_hi", HI, 32'd0);
        chk("mrst_lo", LO, 32'd0);
        repeat (12) @(negedge clk);
        chk("late_busy", {31'd0, busy}, 32'd0);
        chk("late_hi", HI, 32'd0);
        chk("late_lo", LO, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/e_mdu_ctrl.md
Name: e_mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller for the E stage, alongside the single-cycle E-stage ALU.
- Accepts mult/multu/div/divu and latches the operands, then holds `busy` for a fixed latency before committing the result to the HI/LO registers.
- Also serves mfhi/mflo/mthi/mtlo.
- `busy` feeds the hazard unit, which stalls D-stage MD instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be ≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be ≥1)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- in1  in  32  rs operand (forwarded value from E stage)
- in2  in  32  rt operand (forwarded value from E stage)
- MDUop  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–15 treated as none
- busy  out  1  operation in flight
- HI  out  32  HI register
- LO  out  32  LO register
- MDUout  out  32  mfhi → HI, mflo → LO, otherwise 0 (combinational)

Behaviour:
- **Reset** (reset==0 at an edge):
  - HI=0, LO=0, busy=0.
  - Counter=0, state=IDLE, latched operands and op cleared.
  - Overrides every other input.
  - Reset mid-operation discards the pending result and leaves HI/LO=0.
- **State machine** has two states, IDLE and RUN, with a down-counter sized for max(MULT_CYCLES, DIV_CYCLES).
- **IDLE, MDUop in 1..4 at edge:**
  - Latch in1, in2 and the op.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
  - busy=1 from the next cycle.
- **RUN:**
  - Counter decrements each edge.
  - At the edge where counter==1, HI/LO load the result, state goes to IDLE and busy goes to 0.
  - busy is therefore high for exactly N cycles. The new HI/LO are visible in the first cycle busy is low.
- **busy** is registered, driven directly from state (RUN).
- **mult:**
  - Signed 32x32 → 64-bit product.
  - HI = product[63:32], LO = product[31:0].
- **multu:** unsigned version of mult.
- **div:**
  - LO = quotient, truncated toward zero.
  - HI = remainder, taking the sign of the dividend in1.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- **divu:** unsigned version of div.
- **Divide by zero:**
  - The full DIV_CYCLES busy period still runs.
  - HI/LO are left unchanged at completion.
- **Result timing:** may be computed combinationally from the latched operands at the completion edge, or iteratively, provided the cycle timing above holds exactly.
- **mthi / mtlo** in IDLE:
  - HI<=in1 (mthi) or LO<=in1 (mtlo) at the edge.
  - No busy period.
- **mfhi / mflo:** MDUout reflects the current HI/LO combinationally; no state change.
- **Any MDUop while RUN** (including mthi/mtlo): ignored; no state change, operands not re-latched. The hazard unit guarantees this does not occur in correct operation.
- **mfhi/mflo while RUN:** MDUout returns the old HI/LO values.
- **Completion edge with MDUop≠0** (the new op arrives while busy is still 1): the new op is ignored.
- **Next op after completion:** the earliest new start is the cycle in which busy==0.

Test Plan:
- **Signed mult:** mult in1=0xFFFFFFFD, in2=5 → busy=1 for exactly 5 cycles → HI=0xFFFFFFFF, LO=0xFFFFFFF1 in the first cycle busy=0.
- **Unsigned mult:** multu 0xFFFFFFFF × 2 → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- **Signed div:** div 0xFFFFFFF9 (−7) / 2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **Unsigned div:** divu 0xFFFFFFF9 / 2 → LO=0x7FFFFFFC, HI=0x00000001.
- **Divide by zero:** mthi 0x1234, mtlo 0x5678, then div x/0 → busy 10 cycles, then HI=0x1234, LO=0x5678.
- **Move/from and reset:**
  - mthi 0xDEADBEEF then mfhi → MDUout=0xDEADBEEF the next cycle with no busy period.
  - mult issued while busy (e.g. cycle 3 of a div) is ignored.
  - reset=0 during cycle 4 of a div → busy=0, HI=LO=0, and no later write occurs.
